// File: rtl/cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : cic_decimator
// Description : Multi-channel CIC (Hogenauer) decimator for 1-bit PDM /
//               sigma-delta bitstreams. N integrators at the input rate, one
//               shared phase counter, N combs at the output rate, then a
//               round / saturate / format stage. Warm-up frames are blanked.
// Revision    : 1.0 - initial release
// ============================================================================
module cic_decimator #(
  parameter int CH         = 2,
  parameter int N          = 3,
  parameter int DEC_LOG2   = 5,
  parameter int OUT_W      = 8,
  parameter int OUT_SIGNED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       in,
  input  logic                in_en,
  output logic [CH*OUT_W-1:0] out,
  output logic                out_valid,
  output logic [CH-1:0]       sat
);

  // Accumulator width covers the full CIC gain plus sign and one guard bit.
  localparam int ACC_W  = N * DEC_LOG2 + 2;
  // Right-shift that maps the comb output onto OUT_W bits.
  localparam int S      = N * DEC_LOG2 - OUT_W + 1;
  // Width of the rounded/shifted value: always one bit wider than the output.
  localparam int R_W    = OUT_W + 1;
  localparam int WARM_W = $clog2(N + 1);

  localparam logic [DEC_LOG2-1:0] PHASE_LAST = '1;
  localparam logic [WARM_W-1:0]   WARM_DONE  = WARM_W'(N);
  localparam logic [OUT_W-1:0]    MSB_MASK   = OUT_W'(1) << (OUT_W - 1);
  // XOR mask applied after saturation; also the reset value (zero code).
  localparam logic [OUT_W-1:0]    INV_MASK   = (OUT_SIGNED != 0) ? '0 : MSB_MASK;

  generate
    if (N < 1 || DEC_LOG2 < 1 || N * DEC_LOG2 < OUT_W - 1) begin : g_bad_params
      $error("cic_decimator: illegal parameter set (N=%0d DEC_LOG2=%0d OUT_W=%0d)",
             N, DEC_LOG2, OUT_W);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Shared timing: phase counter, frame pipeline flags, warm-up counter
  // --------------------------------------------------------------------------
  logic [DEC_LOG2-1:0] phase_q, phase_d;
  logic                frame1_q, frame1_d;   // comb stage evaluates this edge
  logic                frame2_q, frame2_d;   // output stage evaluates this edge
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                out_valid_q, out_valid_d;
  logic                out_fire;

  // Next-state for phase, frame flags and warm-up blanking.
  always_comb begin
    phase_d     = phase_q;
    frame1_d    = 1'b0;
    frame2_d    = frame1_q;
    warm_d      = warm_q;
    out_fire    = 1'b0;
    if (in_en) begin
      phase_d  = phase_q + 1'b1;
      frame1_d = (phase_q == PHASE_LAST);
    end
    if (frame2_q) begin
      if (warm_q == WARM_DONE) begin
        out_fire = 1'b1;
      end else begin
        warm_d = warm_q + 1'b1;
      end
    end
    out_valid_d = out_fire;
  end

  // Shared timing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= '0;
      frame1_q    <= 1'b0;
      frame2_q    <= 1'b0;
      warm_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      frame1_q    <= frame1_d;
      frame2_q    <= frame2_d;
      warm_q      <= warm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  // --------------------------------------------------------------------------
  // Per-channel datapath
  // --------------------------------------------------------------------------
  genvar c;
  generate
    for (c = 0; c < CH; c++) begin : g_ch
      logic [ACC_W-1:0] integ_q [N];
      logic [ACC_W-1:0] integ_d [N];
      logic [ACC_W-1:0] dly_q   [N];
      logic [ACC_W-1:0] dly_d   [N];
      logic [ACC_W-1:0] comb_q, comb_d;
      logic [R_W-1:0]   scaled;
      logic [OUT_W-1:0] clip;
      logic [OUT_W-1:0] word_q, word_d;
      logic             sat_q, sat_d;
      logic             over;

      // Integrator cascade; each stage adds the freshly updated previous stage.
      always_comb begin
        for (int k = 0; k < N; k++) begin
          integ_d[k] = integ_q[k];
        end
        if (in_en) begin
          integ_d[0] = integ_q[0] + (in[c] ? ACC_W'(1) : {ACC_W{1'b1}});
          for (int k = 1; k < N; k++) begin
            integ_d[k] = integ_q[k] + integ_d[k-1];
          end
        end
      end

      // Comb cascade on the frame edge; delay registers only move on frames.
      always_comb begin : p_comb
        logic [ACC_W-1:0] stage_v;
        stage_v = integ_q[N-1];
        comb_d  = comb_q;
        for (int k = 0; k < N; k++) begin
          dly_d[k] = dly_q[k];
        end
        if (frame1_q) begin
          for (int k = 0; k < N; k++) begin
            dly_d[k] = stage_v;
            stage_v  = stage_v - dly_q[k];
          end
          comb_d = stage_v;
        end
      end

      // Round-half-up then arithmetic shift; floor is just dropping low bits.
      if (S > 0) begin : g_round
        localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (S - 1);
        logic [ACC_W-1:0] rounded;
        logic [S-1:0]     unused_frac;
        assign rounded     = comb_q + RND;
        assign scaled      = rounded[ACC_W-1:S];
        assign unused_frac = rounded[S-1:0];
      end else begin : g_exact
        assign scaled = comb_q;
      end

      // Clip when the two top bits disagree, then apply output format.
      always_comb begin
        over   = (scaled[R_W-1] != scaled[R_W-2]);
        clip   = scaled[OUT_W-1:0];
        word_d = word_q;
        sat_d  = sat_q;
        if (over) begin
          clip = scaled[R_W-1] ? MSB_MASK : ~MSB_MASK;
        end
        if (out_fire) begin
          word_d = clip ^ INV_MASK;
          sat_d  = over;
        end
      end

      // Per-channel state registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < N; k++) begin
            integ_q[k] <= '0;
            dly_q[k]   <= '0;
          end
          comb_q <= '0;
          word_q <= INV_MASK;
          sat_q  <= 1'b0;
        end else begin
          for (int k = 0; k < N; k++) begin
            integ_q[k] <= integ_d[k];
            dly_q[k]   <= dly_d[k];
          end
          comb_q <= comb_d;
          word_q <= word_d;
          sat_q  <= sat_d;
        end
      end

      assign out[c*OUT_W +: OUT_W] = word_q;
      assign sat[c]                = sat_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_decimator
// Description : Scoreboard bench for cic_decimator. Expected samples come from
//               a direct convolution with the CIC impulse response over the
//               full post-reset input history; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decimator;

  localparam int CH       = 2;
  localparam int N        = 3;
  localparam int DEC_LOG2 = 5;
  localparam int OUT_W    = 8;
  localparam int R        = 1 << DEC_LOG2;
  localparam int S        = N * DEC_LOG2 - OUT_W + 1;
  localparam int HLEN     = N * (R - 1) + 1;
  localparam int OMAX     = (1 << (OUT_W - 1)) - 1;
  localparam int OMIN     = -(1 << (OUT_W - 1));

  typedef struct {
    logic [CH*OUT_W-1:0] o;
    logic [CH-1:0]       s;
    int                  cyc;
  } exp_t;

  logic                clk     = 1'b0;
  logic                rst_n   = 1'b0;
  logic [CH-1:0]       in_bits = '0;
  logic                in_en   = 1'b0;
  logic [CH*OUT_W-1:0] out_s, out_o;
  logic                valid_s, valid_o;
  logic [CH-1:0]       sat_s, sat_o;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  exp_t                sb[$];
  exp_t                mon_e;
  logic [CH-1:0]       hist[$];
  int                  h [HLEN];
  logic [CH*OUT_W-1:0] inv_mask;

  cic_decimator #(
    .CH(CH), .N(N), .DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W), .OUT_SIGNED(1)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .in(in_bits), .in_en(in_en),
    .out(out_s), .out_valid(valid_s), .sat(sat_s)
  );

  cic_decimator #(
    .CH(CH), .N(N), .DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W), .OUT_SIGNED(0)
  ) dut_o (
    .clk(clk), .rst_n(rst_n), .in(in_bits), .in_en(in_en),
    .out(out_o), .out_valid(valid_o), .sat(sat_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Impulse response of N cascaded length-R boxcars.
  task automatic build_h();
    int cur [HLEN];
    int nxt [HLEN];
    for (int i = 0; i < HLEN; i++) cur[i] = 0;
    cur[0] = 1;
    repeat (N) begin
      for (int i = 0; i < HLEN; i++) begin
        nxt[i] = 0;
        for (int k = 0; k < R; k++) begin
          if (i - k >= 0) nxt[i] += cur[i - k];
        end
      end
      cur = nxt;
    end
    h = cur;
  endtask

  // Exact filter output for the frame ending at the newest history sample.
  function automatic exp_t frame_expect();
    exp_t e;
    int   t;
    int   y;
    int   v;
    t   = hist.size() - 1;
    e.o = '0;
    e.s = '0;
    e.cyc = 0;
    for (int c = 0; c < CH; c++) begin
      y = 0;
      for (int j = 0; j < HLEN; j++) begin
        if (t - j >= 0) y += hist[t - j][c] ? h[j] : -h[j];
      end
      if (S > 0) v = (y + (1 << (S - 1))) >>> S;
      else       v = y;
      if (v > OMAX) begin
        v = OMAX;
        e.s[c] = 1'b1;
      end else if (v < OMIN) begin
        v = OMIN;
        e.s[c] = 1'b1;
      end
      e.o[c*OUT_W +: OUT_W] = v[OUT_W-1:0];
    end
    return e;
  endfunction

  // One input cycle; enabled samples go into the history, frames into the scoreboard.
  task automatic drive(input logic [CH-1:0] b, input logic en);
    exp_t e;
    @(posedge clk);
    #1;
    in_bits = b;
    in_en   = en;
    if (en) begin
      hist.push_back(b);
      if (hist.size() % R == 0 && hist.size() / R > N) begin
        e     = frame_expect();
        e.cyc = cyc + 3;
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_en = 1'b0;
    sb.delete();
    hist.delete();
    repeat (n) begin
      @(negedge clk);
      check("rst_out_signed", 32'(out_s), 32'h0);
      check("rst_out_offset", 32'(out_o), 32'(inv_mask));
      check("rst_valid", {30'h0, valid_s, valid_o}, 32'h0);
      check("rst_sat", {28'h0, sat_s, sat_o}, 32'h0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe is matched against the scoreboard head.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("strobe_missing", 32'(cyc), 32'(sb[0].cyc));
      void'(sb.pop_front());
    end
    if (valid_s || valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", {30'h0, valid_s, valid_o}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_time", 32'(cyc), 32'(mon_e.cyc));
        check("valid_pair", {30'h0, valid_s, valid_o}, 32'h3);
        check("out_signed", 32'(out_s), 32'(mon_e.o));
        check("out_offset", 32'(out_o), 32'(mon_e.o ^ inv_mask));
        check("sat_signed", 32'(sat_s), 32'(mon_e.s));
        check("sat_offset", 32'(sat_o), 32'(mon_e.s));
      end
    end
  end

  initial begin
    #(200000 * 10);
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [CH-1:0] b;
    build_h();
    inv_mask = '0;
    for (int c = 0; c < CH; c++) inv_mask[c*OUT_W + OUT_W - 1] = 1'b1;

    do_reset(4);

    // Full-scale positive, then full-scale negative.
    repeat (8 * R) drive('1, 1'b1);
    repeat (8 * R) drive('0, 1'b1);

    // ch0 alternating 1010..., ch1 repeating 1110.
    for (int i = 0; i < 8 * R; i++) begin
      b[0] = (i % 2 == 0);
      b[1] = (i % 4 != 3);
      drive(b, 1'b1);
    end

    // Sample enable toggling every cycle with all-ones input.
    for (int i = 0; i < 16 * R; i++) drive('1, (i % 2 == 0));

    // Reset in the middle of a frame at phase 17.
    while (hist.size() % R != 17) drive('1, 1'b1);
    do_reset(3);
    repeat (6 * R) drive('1, 1'b1);

    // Random bitstreams with a random sample enable.
    for (int i = 0; i < 700 * R; i++) begin
      drive(CH'($urandom), ($urandom_range(3, 0) != 0));
    end

    repeat (8) drive('0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
